// File: rtl/algo_1r1w_dl_t1_pkg.sv
// Shared definitions for the t1 banked-DRAM responder.
//   - ERR_* : bit positions of the per-cycle violation vector
//   - t1_rd_stage_t : one read-pipeline stage {valid, data}
//   - rbank_of() : vbank -> refresh-bank mapping (bank mod NUMRBNK)
// The stage data width is T1_PHYWDTH; a responder built with a different
// PHYWDTH needs this constant changed to match.
package algo_1r1w_dl_t1_pkg;

    localparam int unsigned T1_PHYWDTH   = 32;

    localparam int unsigned ERR_CONFLICT = 0;
    localparam int unsigned ERR_REFR     = 1;
    localparam int unsigned ERR_STARVE   = 2;
    localparam int unsigned ERR_NUM      = 3;

    typedef struct packed {
        logic                  valid;
        logic [T1_PHYWDTH-1:0] data;
    } t1_rd_stage_t;

    function automatic int unsigned rbank_of(input int unsigned vbank,
                                             input int unsigned numrbnk);
        return vbank % numrbnk;
    endfunction

endpackage

// File: rtl/algo_1r1w_dl_refr_monitor.sv
// Per-rbank refresh starvation monitor.
// One counter per rbank: cleared by reset or by a refresh of that rbank,
// otherwise +1 per cycle, saturating at all-ones.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   i_refr, i_bank  : refresh strobe and refresh bank
//   o_onset         : combinational, a counter reaches REFLIMIT+1 at this edge
//   o_err_starve    : sticky starvation flag
// BITRLIM must be wide enough that all-ones >= REFLIMIT+1.
module algo_1r1w_dl_refr_monitor #(
    parameter int NUMRBNK  = 4,
    parameter int BITRBNK  = 2,
    parameter int REFLIMIT = 48,
    parameter int BITRLIM  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_refr,
    input  logic [BITRBNK-1:0] i_bank,
    output logic               o_onset,
    output logic               o_err_starve
);

    logic [BITRLIM-1:0] r_cnt [NUMRBNK];
    logic [NUMRBNK-1:0] w_hit;
    logic [NUMRBNK-1:0] w_onset;
    logic               r_err_starve;

    // Decode which rbank is refreshed and which counter is about to pass REFLIMIT.
    always_comb begin
        w_hit   = '0;
        w_onset = '0;
        for (int r = 0; r < NUMRBNK; r++) begin
            if (i_refr && (i_bank == BITRBNK'(r))) begin
                w_hit[r] = 1'b1;
            end else begin
                w_hit[r] = 1'b0;
            end
            // Onset is the single increment from REFLIMIT to REFLIMIT+1.
            if (!w_hit[r] && (r_cnt[r] == BITRLIM'(REFLIMIT))) begin
                w_onset[r] = 1'b1;
            end else begin
                w_onset[r] = 1'b0;
            end
        end
    end

    // Starvation counters, one per rbank.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUMRBNK; r++) begin
            if (!rst) begin
                r_cnt[r] <= '0;
            end else if (w_hit[r]) begin
                r_cnt[r] <= '0;
            end else if (r_cnt[r] != {BITRLIM{1'b1}}) begin
                r_cnt[r] <= r_cnt[r] + BITRLIM'(1);
            end
        end
    end

    // Sticky starvation flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_starve <= 1'b0;
        end else if (|w_onset) begin
            r_err_starve <= 1'b1;
        end
    end

    assign o_onset      = |w_onset;
    assign o_err_starve = r_err_starve;

endmodule

// File: rtl/algo_1r1w_dl_t1_responder.sv
// Memory-side model of the t1 banked-DRAM interface (1R1W dl core).
// Port A writes with per-bit enables, port B reads with fixed latency DELAY
// (>= 1), port C refreshes. Protocol violations raise sticky flags and a
// saturating violation-cycle count.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   t1_writeA/bankA/addrA/bwA/dinA/dwsnA : write port (dwsnA captured, unused)
//   t1_readB/bankB/addrB/dwsnB/doutB     : read port (dwsnB unused)
//   t1_refrC/bankC           : refresh port
//   err_conflict/err_refr/err_starve     : sticky violation flags
//   err_cnt                  : cycles with any violation, saturating
// Optional feature macro: ALGO_DL_T1_ERRINJ_EN adds inj_flip/inj_mask, which
// XOR the data of a read issued with inj_flip=1 (storage untouched).
module algo_1r1w_dl_t1_responder
    import algo_1r1w_dl_t1_pkg::*;
#(
    parameter int NUMVBNK  = 4,
    parameter int BITVBNK  = 2,
    parameter int NUMSROW  = 2048,
    parameter int BITSROW  = 11,
    parameter int PHYWDTH  = T1_PHYWDTH,
    parameter int DELAY    = 2,
    parameter int NUMRBNK  = 4,
    parameter int BITRBNK  = 2,
    parameter int BITDWSN  = 8,
    parameter int REFLIMIT = 48,
    parameter int BITRLIM  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               t1_writeA,
    input  logic [BITVBNK-1:0] t1_bankA,
    input  logic [BITSROW-1:0] t1_addrA,
    input  logic [PHYWDTH-1:0] t1_bwA,
    input  logic [PHYWDTH-1:0] t1_dinA,
    input  logic [BITDWSN-1:0] t1_dwsnA,
    input  logic               t1_readB,
    input  logic [BITVBNK-1:0] t1_bankB,
    input  logic [BITSROW-1:0] t1_addrB,
    input  logic [BITDWSN-1:0] t1_dwsnB,
    output logic [PHYWDTH-1:0] t1_doutB,
    input  logic               t1_refrC,
    input  logic [BITRBNK-1:0] t1_bankC,
`ifdef ALGO_DL_T1_ERRINJ_EN
    input  logic               inj_flip,
    input  logic [PHYWDTH-1:0] inj_mask,
`endif
    output logic               err_conflict,
    output logic               err_refr,
    output logic               err_starve,
    output logic [15:0]        err_cnt
);

    logic [PHYWDTH-1:0]         r_mem [NUMVBNK*NUMSROW];
    logic [BITVBNK+BITSROW-1:0] w_waddr;
    logic [BITVBNK+BITSROW-1:0] w_raddr;
    t1_rd_stage_t               w_stage_in;
    t1_rd_stage_t               r_pipe [DELAY];
    logic [ERR_NUM-1:0]         w_viol;
    logic [BITRBNK-1:0]         w_rbank_a;
    logic [BITRBNK-1:0]         w_rbank_b;
    logic                       w_starve_onset;
    logic                       r_err_conflict;
    logic                       r_err_refr;
    logic [15:0]                r_err_cnt;
    logic [BITDWSN-1:0]         r_dwsna_unused;
    logic                       w_unused;

    assign w_waddr   = {t1_bankA, t1_addrA};
    assign w_raddr   = {t1_bankB, t1_addrB};
    assign w_rbank_a = BITRBNK'(rbank_of(32'(t1_bankA), 32'(NUMRBNK)));
    assign w_rbank_b = BITRBNK'(rbank_of(32'(t1_bankB), 32'(NUMRBNK)));
    assign w_unused  = ^{t1_dwsnB, r_dwsna_unused};

    // Storage: bit-masked write; reset leaves contents alone but blocks writes.
    always_ff @(posedge clk) begin
        if (rst && t1_writeA) begin
            r_mem[w_waddr] <= (r_mem[w_waddr] & ~t1_bwA) | (t1_dinA & t1_bwA);
        end
    end

    // Sideband capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dwsna_unused <= '0;
        end else begin
            r_dwsna_unused <= t1_dwsnA;
        end
    end

    // Pipeline entry: the array read sees pre-write contents of this edge.
    always_comb begin
        w_stage_in.valid = t1_readB;
`ifdef ALGO_DL_T1_ERRINJ_EN
        if (inj_flip) begin
            w_stage_in.data = r_mem[w_raddr] ^ inj_mask;
        end else begin
            w_stage_in.data = r_mem[w_raddr];
        end
`else
        w_stage_in.data = r_mem[w_raddr];
`endif
    end

    // DELAY-deep read shift register; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DELAY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int i = 1; i < DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign t1_doutB = r_pipe[DELAY-1].valid ? r_pipe[DELAY-1].data : '0;

    // Per-cycle protocol violation decode.
    always_comb begin
        w_viol = '0;
        if (t1_writeA && t1_readB && (t1_bankA == t1_bankB)) begin
            w_viol[ERR_CONFLICT] = 1'b1;
        end else begin
            w_viol[ERR_CONFLICT] = 1'b0;
        end
        if (t1_refrC && ((t1_writeA && (w_rbank_a == t1_bankC)) ||
                         (t1_readB  && (w_rbank_b == t1_bankC)))) begin
            w_viol[ERR_REFR] = 1'b1;
        end else begin
            w_viol[ERR_REFR] = 1'b0;
        end
        w_viol[ERR_STARVE] = w_starve_onset;
    end

    // Sticky flags and saturating violation-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_conflict <= 1'b0;
            r_err_refr     <= 1'b0;
            r_err_cnt      <= 16'h0000;
        end else begin
            if (w_viol[ERR_CONFLICT]) begin
                r_err_conflict <= 1'b1;
            end
            if (w_viol[ERR_REFR]) begin
                r_err_refr <= 1'b1;
            end
            if ((|w_viol) && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    algo_1r1w_dl_refr_monitor #(
        .NUMRBNK  (NUMRBNK),
        .BITRBNK  (BITRBNK),
        .REFLIMIT (REFLIMIT),
        .BITRLIM  (BITRLIM)
    ) u_refr_monitor (
        .clk          (clk),
        .rst          (rst),
        .i_refr       (t1_refrC),
        .i_bank       (t1_bankC),
        .o_onset      (w_starve_onset),
        .o_err_starve (err_starve)
    );

    assign err_conflict = r_err_conflict;
    assign err_refr     = r_err_refr;
    assign err_cnt      = r_err_cnt;

endmodule
